piso_stream: RTL and testbench

PISO_STREAM -- requirements
Module: PISO_STREAM

---
 rtl/piso_pkg.sv | 18 +
 rtl/piso_stream_word_fifo.sv | 76 +++++++
 rtl/piso_stream.sv | 185 ++++++++++++++++++
 tb/tb_piso_stream.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_stream parallel-in / serial-out block.
package piso_pkg;

    // Serializer control states. PARITY is only entered when the
    // PISO_STREAM_PARITY_EN build option is compiled in.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_e;

    // Width of a counter that indexes the bits of a WIDTH-bit word.
    // Never narrower than one bit so the counter always exists.
    function automatic int unsigned idx_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_stream_word_fifo.sv
// word_fifo: small circular word buffer feeding the piso_stream active register.
// Head word is visible combinationally on rdata_o; push/pop/clear act on the
// rising edge; rst_i clears pointers and count asynchronously.
module word_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Guard the handshakes so an illegal push/pop can never corrupt the pointers.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy next state; clear discards everything at once.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array: contents need no reset, the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push_ok && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/piso_stream.sv
// piso_stream: parallel words in through a ready/valid handshake, one serial
// bit out per SHIFT_EN cycle. A word offered while nothing is buffered goes
// straight into the active register; otherwise it waits in word_fifo.
// Build option: define PISO_STREAM_PARITY_EN to append an even-parity bit
// after every word (WORD_DONE then marks the parity bit).
module piso_stream
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [WIDTH-1:0]           DATA_IN,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic                       SHIFT_EN,
    input  logic                       FLUSH,
    output logic                       DATA,
    output logic                       DATA_VALID,
    output logic                       WORD_DONE,
    output logic [$clog2(DEPTH+1)-1:0] LEVEL
);

    localparam int IDX_W = int'(idx_width(WIDTH));
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    piso_state_e      state_q, state_d;
    logic [WIDTH-1:0] act_q, act_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             data_q, data_d;
    logic             dv_q, dv_d;
    logic             done_q, done_d;

    logic             accept;
    logic             push;
    logic             pop;
    logic             bypass;
    logic             last_bit;
    logic             cur_bit;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_count;

    assign IN_READY   = !fifo_full;
    assign accept     = IN_VALID && IN_READY;
    assign last_bit   = (idx_q == LAST_IDX);
    assign cur_bit    = (MSB_FIRST != 0) ? act_q[LAST_IDX - idx_q] : act_q[idx_q];

    assign DATA       = data_q;
    assign DATA_VALID = dv_q;
    assign WORD_DONE  = done_q;
    assign LEVEL      = fifo_count;

    word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .clear_i (FLUSH),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (DATA_IN),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // State register plus the datapath registers it governs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            act_q   <= '0;
            idx_q   <= '0;
            data_q  <= 1'b0;
            dv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            done_q  <= done_d;
        end
    end

    // Next state and word movement: bypass load, FIFO pop on the final bit
    // (no bubble), FIFO push for every other accepted word.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        bypass  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = SHIFT;
                end else if (accept) begin
                    bypass  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (SHIFT_EN && last_bit) begin
`ifdef PISO_STREAM_PARITY_EN
                    state_d = PARITY;
`else
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end
            end
`ifdef PISO_STREAM_PARITY_EN
            PARITY: begin
                if (SHIFT_EN) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        push = accept && !bypass;
        // Flush wins over everything, including a concurrent handshake.
        if (FLUSH) begin
            state_d = IDLE;
            pop     = 1'b0;
            push    = 1'b0;
            bypass  = 1'b0;
        end
    end

    // Registered serial outputs, bit index and active word next values.
    always_comb begin
        data_d = 1'b0;
        dv_d   = 1'b0;
        done_d = 1'b0;
        idx_d  = idx_q;
        act_d  = act_q;
        if (state_q == SHIFT && SHIFT_EN) begin
            data_d = cur_bit;
            dv_d   = 1'b1;
`ifndef PISO_STREAM_PARITY_EN
            done_d = last_bit;
`endif
            idx_d  = last_bit ? '0 : idx_q + 1'b1;
        end
`ifdef PISO_STREAM_PARITY_EN
        if (state_q == PARITY && SHIFT_EN) begin
            data_d = ^act_q;
            dv_d   = 1'b1;
            done_d = 1'b1;
        end
`endif
        if (pop) begin
            act_d = fifo_rdata;
            idx_d = '0;
        end else if (bypass) begin
            act_d = DATA_IN;
            idx_d = '0;
        end
        if (FLUSH) begin
            data_d = 1'b0;
            dv_d   = 1'b0;
            done_d = 1'b0;
            idx_d  = '0;
            act_d  = '0;
        end
    end

endmodule

// File: tb/tb_piso_stream.sv
// Directed bench for piso_stream with a bit-level scoreboard: every accepted
// word pushes its expected serial bits, monitors pop them as DATA_VALID bits appear.
module tb_piso_stream;

`ifdef PISO_STREAM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int BPW = 8 + (PAR ? 1 : 0);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = '0;
    logic       vin = 1'b0, sen = 1'b0, flush = 1'b0;
    logic       in_rdy, dout, dval, wdone;
    logic [2:0] lvl;

    logic [2:0] din3 = '0;
    logic       vin3 = 1'b0, sen3 = 1'b0;
    logic       rdy3, d3, v3, done3;
    logic [1:0] lvl3;

    int         npass = 0, ntotal = 0;
    logic [1:0] q  [$];
    logic [1:0] q3 [$];
    logic [7:0] words [5] = '{8'h5A, 8'hC3, 8'h01, 8'h80, 8'hF0};

    always #5 clk = ~clk;

    piso_stream #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(0)) dut (
        .CLK(clk), .RST(rst), .DATA_IN(din), .IN_VALID(vin), .IN_READY(in_rdy),
        .SHIFT_EN(sen), .FLUSH(flush), .DATA(dout), .DATA_VALID(dval),
        .WORD_DONE(wdone), .LEVEL(lvl)
    );

    piso_stream #(.WIDTH(3), .DEPTH(2), .MSB_FIRST(1)) dut3 (
        .CLK(clk), .RST(rst), .DATA_IN(din3), .IN_VALID(vin3), .IN_READY(rdy3),
        .SHIFT_EN(sen3), .FLUSH(1'b0), .DATA(d3), .DATA_VALID(v3),
        .WORD_DONE(done3), .LEVEL(lvl3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected serial stream for an 8-bit LSB-first word.
    task automatic expect8(input logic [7:0] w);
        for (int i = 0; i < 8; i++) q.push_back({w[i], (i == 7) && !PAR});
        if (PAR) q.push_back({^w, 1'b1});
    endtask

    // Expected serial stream for a 3-bit MSB-first word.
    task automatic expect3(input logic [2:0] w);
        for (int i = 2; i >= 0; i--) q3.push_back({w[i], (i == 0) && !PAR});
        if (PAR) q3.push_back({^w, 1'b1});
    endtask

    task automatic send8(input logic [7:0] w);
        chk("in_ready_before_send", 32'(in_rdy), 32'd1);
        vin = 1'b1;
        din = w;
        expect8(w);
        tick();
        vin = 1'b0;
    endtask

    always @(negedge clk) begin : mon8
        logic [1:0] e;
        if (dval === 1'b1) begin
            if (q.size() == 0) chk("spurious_valid", 32'(dval), 32'd0);
            else begin
                e = q.pop_front();
                chk("bit8", 32'({dout, wdone}), 32'(e));
            end
        end else chk("idle8_outputs", 32'({dval, dout, wdone}), 32'd0);
    end

    always @(negedge clk) begin : mon3
        logic [1:0] e;
        if (v3 === 1'b1) begin
            if (q3.size() == 0) chk("spurious_valid3", 32'(v3), 32'd0);
            else begin
                e = q3.pop_front();
                chk("bit3", 32'({d3, done3}), 32'(e));
            end
        end else chk("idle3_outputs", 32'({v3, d3, done3}), 32'd0);
    end

    initial begin : stim
        int cnt;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", 32'({dout, dval, wdone}), 32'd0);
        chk("rst_level", 32'(lvl), 32'd0);
        chk("rst_ready", 32'(in_rdy), 32'd1);
        chk("rst_ready3", 32'(rdy3), 32'd1);
        rst = 1'b0;
        tick();

        // Single word 8'h03, LSB first, first bit one edge after acceptance
        sen = 1'b1;
        send8(8'h03);
        tick();
        chk("first_bit_latency", 32'({dval, dout}), 32'b11);
        repeat (BPW + 3) tick();
        chk("drain_single", 32'(q.size()), 32'd0);

        // Five words with SHIFT_EN low: one active, four buffered
        sen = 1'b0;
        for (int i = 0; i < 5; i++) send8(words[i]);
        chk("level_full", 32'(lvl), 32'd4);
        chk("ready_full", 32'(in_rdy), 32'd0);
        repeat (3) tick();
        chk("held_no_valid", 32'(dval), 32'd0);
        chk("held_level", 32'(lvl), 32'd4);
        sen = 1'b1;
        cnt = 0;
        repeat (5 * BPW) begin
            tick();
            if (dval === 1'b1) cnt++;
        end
        chk("contiguous_bits", 32'(cnt), 32'(5 * BPW));
        tick();
        chk("after_drain_valid", 32'(dval), 32'd0);
        chk("after_drain_level", 32'(lvl), 32'd0);
        chk("drain_burst", 32'(q.size()), 32'd0);

        // Reset in the middle of 8'hFF
        send8(8'hFF);
        repeat (3) tick();
        chk("inflight_valid", 32'(dval), 32'd1);
        #1;
        rst = 1'b1;
        q.delete();
        #1;
        chk("async_rst_outputs", 32'({dout, dval, wdone}), 32'd0);
        chk("async_rst_ready", 32'(in_rdy), 32'd1);
        tick();
        tick();
        rst = 1'b0;
        cnt = 0;
        repeat (12) begin
            tick();
            if (dval === 1'b1) cnt++;
        end
        chk("post_reset_valid_cnt", 32'(cnt), 32'd0);

        // Flush during first of two words, with a handshake on the flush edge
        send8(8'hA5);
        send8(8'h3C);
        chk("level_one", 32'(lvl), 32'd1);
        repeat (2) tick();
        @(negedge clk);
        #1;
        flush = 1'b1;
        vin   = 1'b1;
        din   = 8'h77;
        q.delete();
        @(posedge clk);
        #1;
        flush = 1'b0;
        vin   = 1'b0;
        chk("flush_level", 32'(lvl), 32'd0);
        chk("flush_valid", 32'(dval), 32'd0);
        chk("flush_ready", 32'(in_rdy), 32'd1);
        cnt = 0;
        repeat (16) begin
            tick();
            if (dval === 1'b1) cnt++;
        end
        chk("post_flush_valid_cnt", 32'(cnt), 32'd0);

        // MSB-first, WIDTH=3: 3'b011 then 3'b100
        sen3 = 1'b1;
        vin3 = 1'b1;
        din3 = 3'b011;
        expect3(3'b011);
        tick();
        din3 = 3'b100;
        expect3(3'b100);
        tick();
        vin3 = 1'b0;
        chk("msb_first_bit", 32'({v3, d3}), 32'b10);
        chk("level3", 32'(lvl3), 32'd1);
        repeat (10) tick();
        chk("drain_msb", 32'(q3.size()), 32'd0);

        chk("drain_final", 32'(q.size() + q3.size()), 32'd0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
